gpio_apb_arbiter: RTL and testbench

Two-requester APB arbiter that shares one APB completer, the GPIO register block on the uncore APB bus, between two APB requesters. Typical requesters are the core's APB bridge (M0) and the debug/boot configuration engine (M1). The block sequences each granted transfer through its own SETUP/ACCESS phases toward the completer. It arbitrates round-robin and guards against a hung completer with a timeout that returns PSLVERR.

---
 rtl/gpio_apb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_gpio_apb_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: round-robin arbiter sharing the GPIO APB completer between
// two APB requesters, with an ACCESS-phase timeout that answers PSLVERR.

package config_pkg;
    localparam int unsigned XLEN = 32;
endpackage

module gpio_apb_arbiter #(
    parameter int unsigned XLEN    = config_pkg::XLEN,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    // requester 0
    input  logic                M0_PSEL,
    input  logic                M0_PENABLE,
    input  logic                M0_PWRITE,
    input  logic [ADDR_W-1:0]   M0_PADDR,
    input  logic [XLEN-1:0]     M0_PWDATA,
    input  logic [XLEN/8-1:0]   M0_PSTRB,
    output logic [XLEN-1:0]     M0_PRDATA,
    output logic                M0_PREADY,
    output logic                M0_PSLVERR,
    // requester 1
    input  logic                M1_PSEL,
    input  logic                M1_PENABLE,
    input  logic                M1_PWRITE,
    input  logic [ADDR_W-1:0]   M1_PADDR,
    input  logic [XLEN-1:0]     M1_PWDATA,
    input  logic [XLEN/8-1:0]   M1_PSTRB,
    output logic [XLEN-1:0]     M1_PRDATA,
    output logic                M1_PREADY,
    output logic                M1_PSLVERR,
    // completer
    output logic                S_PSEL,
    output logic                S_PENABLE,
    output logic                S_PWRITE,
    output logic [ADDR_W-1:0]   S_PADDR,
    output logic [XLEN-1:0]     S_PWDATA,
    output logic [XLEN/8-1:0]   S_PSTRB,
    input  logic [XLEN-1:0]     S_PRDATA,
    input  logic                S_PREADY
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t              r_state, w_next_state;
    logic                r_grant, w_next_grant;   // 0 = M0, 1 = M1
    logic                r_last;                  // requester served most recently
    logic [CNT_W-1:0]    r_cnt;
    logic                w_load, w_done, w_timeout, w_other_req;

    logic                r_s_psel, r_s_penable, r_s_pwrite;
    logic [ADDR_W-1:0]   r_s_paddr;
    logic [XLEN-1:0]     r_s_pwdata;
    logic [XLEN/8-1:0]   r_s_pstrb;

    // Next state, grant selection and combinational requester responses.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        w_other_req  = 1'b0;
        M0_PREADY    = 1'b0;
        M0_PSLVERR   = 1'b0;
        M0_PRDATA    = '0;
        M1_PREADY    = 1'b0;
        M1_PSLVERR   = 1'b0;
        M1_PRDATA    = '0;
        case (r_state)
            ST_IDLE: begin
                if (M0_PSEL || M1_PSEL) begin
                    w_next_state = ST_SETUP;
                    w_load       = 1'b1;
                    if (M0_PSEL && M1_PSEL) w_next_grant = ~r_last;
                    else                    w_next_grant = M1_PSEL;
                end
            end
            ST_SETUP: w_next_state = ST_ACCESS;
            ST_ACCESS: begin
                w_timeout = TO_EN && !S_PREADY && (r_cnt == CNT_W'(TIMEOUT - 1));
                w_done    = S_PREADY || w_timeout;
                if (w_done) begin
                    // The served requester's PSEL still belongs to the finished
                    // transfer, so only the other requester can chain a SETUP.
                    w_other_req = r_grant ? M0_PSEL : M1_PSEL;
                    if (w_other_req) begin
                        w_next_state = ST_SETUP;
                        w_next_grant = ~r_grant;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                    if (!r_grant) begin
                        M0_PREADY  = 1'b1;
                        M0_PSLVERR = w_timeout;
                        M0_PRDATA  = w_timeout ? '0 : S_PRDATA;
                    end else begin
                        M1_PREADY  = 1'b1;
                        M1_PSLVERR = w_timeout;
                        M1_PRDATA  = w_timeout ? '0 : S_PRDATA;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, grant, round-robin pointer and timeout counter registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            if (w_done) r_last <= r_grant;
            if (r_state == ST_SETUP)
                r_cnt <= '0;
            else if (r_state == ST_ACCESS && !S_PREADY && !w_timeout)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered completer-side control and captured request fields.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_s_psel    <= 1'b0;
            r_s_penable <= 1'b0;
            r_s_pwrite  <= 1'b0;
            r_s_paddr   <= '0;
            r_s_pwdata  <= '0;
            r_s_pstrb   <= '0;
        end else begin
            r_s_psel    <= (w_next_state != ST_IDLE);
            r_s_penable <= (w_next_state == ST_ACCESS);
            if (w_load) begin
                r_s_pwrite <= w_next_grant ? M1_PWRITE : M0_PWRITE;
                r_s_paddr  <= w_next_grant ? M1_PADDR  : M0_PADDR;
                r_s_pwdata <= w_next_grant ? M1_PWDATA : M0_PWDATA;
                r_s_pstrb  <= w_next_grant ? M1_PSTRB  : M0_PSTRB;
            end
        end
    end

    assign S_PSEL    = r_s_psel;
    assign S_PENABLE = r_s_penable;
    assign S_PWRITE  = r_s_pwrite;
    assign S_PADDR   = r_s_paddr;
    assign S_PWDATA  = r_s_pwdata;
    assign S_PSTRB   = r_s_pstrb;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Self-checking bench for gpio_apb_arbiter (TIMEOUT=4 instance).
module tb_gpio_apb_arbiter;

    logic        PCLK, PRESETn;
    logic        m_psel[2], m_pen[2], m_pwrite[2];
    logic [7:0]  m_paddr[2];
    logic [31:0] m_pwdata[2];
    logic [3:0]  m_pstrb[2];
    logic [31:0] m0_prdata, m1_prdata;
    logic        m0_pready, m1_pready, m0_pslverr, m1_pslverr;
    logic        m_pready[2], m_pslverr[2];
    logic [31:0] m_prdata[2];
    logic        s_psel, s_penable, s_pwrite;
    logic [7:0]  s_paddr;
    logic [31:0] s_pwdata, s_prdata;
    logic [3:0]  s_pstrb;
    logic        s_pready;
    logic [114:0] all_out;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        wr;
        int          m;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    assign m_pready[0]  = m0_pready;
    assign m_pready[1]  = m1_pready;
    assign m_pslverr[0] = m0_pslverr;
    assign m_pslverr[1] = m1_pslverr;
    assign m_prdata[0]  = m0_prdata;
    assign m_prdata[1]  = m1_prdata;
    assign all_out = {s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
                      m0_pready, m0_pslverr, m0_prdata, m1_pready, m1_pslverr, m1_prdata};

    gpio_apb_arbiter #(.XLEN(32), .ADDR_W(8), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .M0_PSEL(m_psel[0]), .M0_PENABLE(m_pen[0]), .M0_PWRITE(m_pwrite[0]),
        .M0_PADDR(m_paddr[0]), .M0_PWDATA(m_pwdata[0]), .M0_PSTRB(m_pstrb[0]),
        .M0_PRDATA(m0_prdata), .M0_PREADY(m0_pready), .M0_PSLVERR(m0_pslverr),
        .M1_PSEL(m_psel[1]), .M1_PENABLE(m_pen[1]), .M1_PWRITE(m_pwrite[1]),
        .M1_PADDR(m_paddr[1]), .M1_PWDATA(m_pwdata[1]), .M1_PSTRB(m_pstrb[1]),
        .M1_PRDATA(m1_prdata), .M1_PREADY(m1_pready), .M1_PSLVERR(m1_pslverr),
        .S_PSEL(s_psel), .S_PENABLE(s_penable), .S_PWRITE(s_pwrite),
        .S_PADDR(s_paddr), .S_PWDATA(s_pwdata), .S_PSTRB(s_pstrb),
        .S_PRDATA(s_prdata), .S_PREADY(s_pready)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog");
    end

    // advance to just after the next rising edge
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            m_psel[i] = 1'b0; m_pen[i] = 1'b0; m_pwrite[i] = 1'b0;
            m_paddr[i] = '0; m_pwdata[i] = '0; m_pstrb[i] = '0;
        end
        s_pready = 1'b0;
        s_prdata = '0;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    task automatic drive_req(input int m, input logic wr, input logic [7:0] a, input logic [31:0] d);
        m_psel[m] = 1'b1; m_pen[m] = 1'b0; m_pwrite[m] = wr;
        m_paddr[m] = a; m_pwdata[m] = d; m_pstrb[m] = 4'hF;
    endtask

    // one full APB transfer from requester m, bounded in cycles
    task automatic apb_xfer(input int m, input logic wr, input logic [7:0] a, input logic [31:0] d,
                            output logic ok);
        drive_req(m, wr, a, d);
        step();
        m_pen[m] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge PCLK);
            if (m_pready[m]) ok = 1'b1;
            step();
        end
        m_psel[m] = 1'b0;
        m_pen[m]  = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        idle_inputs();
        m_psel[0] = 1'b1;
        @(negedge PCLK);
        total++;
        if (all_out !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        m_psel[0] = 1'b0;
        step();
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        total++;
        if (s_psel !== 1'b0) begin
            bad++; $display("FAIL reset_idle: S_PSEL got %b required 0", s_psel);
        end
    endtask

    task automatic test_uncontested_write();
        exp_t e;
        do_reset();
        s_pready = 1'b1;
        drive_req(0, 1'b1, 8'h0C, 32'h0000_00FF);
        sb.push_back('{addr: 8'h0C, data: 32'h0000_00FF, wr: 1'b1, m: 0});
        @(negedge PCLK);                         // cycle 0
        total++;
        if (s_psel !== 1'b0 || m0_pready !== 1'b0) begin
            bad++; $display("FAIL wr_c0: psel=%b pready=%b required 0 0", s_psel, m0_pready);
        end
        step(); m_pen[0] = 1'b1;
        @(negedge PCLK);                         // cycle 1
        total++;
        if ({s_psel, s_penable} !== 2'b10 || s_paddr !== 8'h0C || s_pwdata !== 32'hFF || m0_pready !== 1'b0) begin
            bad++; $display("FAIL wr_setup: psel/pen=%b%b addr=%h wdata=%h pready=%b required 10 0c 000000ff 0",
                            s_psel, s_penable, s_paddr, s_pwdata, m0_pready);
        end
        step();
        @(negedge PCLK);                         // cycle 2
        total++;
        if ({s_psel, s_penable} !== 2'b11 || m0_pready !== 1'b1 || m0_pslverr !== 1'b0) begin
            bad++; $display("FAIL wr_access: psel/pen=%b%b pready=%b pslverr=%b required 11 1 0",
                            s_psel, s_penable, m0_pready, m0_pslverr);
        end
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL wr_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            if (s_paddr !== e.addr || s_pwdata !== e.data || s_pwrite !== e.wr || s_pstrb !== 4'hF) begin
                bad++; $display("FAIL wr_sb: got %h %h %b %h required %h %h %b f",
                                s_paddr, s_pwdata, s_pwrite, s_pstrb, e.addr, e.data, e.wr);
            end
        end
        total++;
        if ({m1_pready, m1_pslverr, m1_prdata} !== '0) begin
            bad++; $display("FAIL wr_m1_quiet: got %b %b %h required 0", m1_pready, m1_pslverr, m1_prdata);
        end
        step(); m_psel[0] = 1'b0; m_pen[0] = 1'b0;
        @(negedge PCLK);                         // cycle 3
        total++;
        if (s_psel !== 1'b0 || m0_pready !== 1'b0) begin
            bad++; $display("FAIL wr_after: psel=%b pready=%b required 0 0", s_psel, m0_pready);
        end
    endtask

    task automatic test_read();
        exp_t e;
        s_pready = 1'b1;
        s_prdata = 32'hA5A5_0001;
        drive_req(1, 1'b0, 8'h00, 32'h0);
        sb.push_back('{addr: 8'h00, data: 32'h0, wr: 1'b0, m: 1});
        step(); m_pen[1] = 1'b1;
        @(negedge PCLK);                         // cycle 1 (SETUP)
        total++;
        if (m1_pready !== 1'b0 || m1_prdata !== 32'h0) begin
            bad++; $display("FAIL rd_setup: pready=%b prdata=%h required 0 00000000", m1_pready, m1_prdata);
        end
        step();
        @(negedge PCLK);                         // cycle 2 (ACCESS)
        total++;
        if (m1_pready !== 1'b1 || m1_prdata !== 32'hA5A5_0001 || m1_pslverr !== 1'b0) begin
            bad++; $display("FAIL rd_access: pready=%b prdata=%h pslverr=%b required 1 a5a50001 0",
                            m1_pready, m1_prdata, m1_pslverr);
        end
        total++;
        if ({m0_pready, m0_pslverr, m0_prdata} !== '0) begin
            bad++; $display("FAIL rd_m0_quiet: got %b %b %h required 0", m0_pready, m0_pslverr, m0_prdata);
        end
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL rd_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            if (s_paddr !== e.addr || s_pwrite !== e.wr) begin
                bad++; $display("FAIL rd_sb: got %h %b required %h %b", s_paddr, s_pwrite, e.addr, e.wr);
            end
        end
        step(); m_psel[1] = 1'b0; m_pen[1] = 1'b0;
    endtask

    task automatic test_simultaneous();
        exp_t e;
        do_reset();
        s_pready = 1'b1;
        drive_req(0, 1'b1, 8'h04, 32'h1111_0000);
        drive_req(1, 1'b1, 8'h08, 32'h2222_0000);
        sb.push_back('{addr: 8'h04, data: 32'h1111_0000, wr: 1'b1, m: 0});
        sb.push_back('{addr: 8'h08, data: 32'h2222_0000, wr: 1'b1, m: 1});
        step(); m_pen[0] = 1'b1; m_pen[1] = 1'b1;
        @(negedge PCLK);                         // cycle 1
        total++;
        if ({s_psel, s_penable} !== 2'b10 || s_paddr !== 8'h04) begin
            bad++; $display("FAIL tie_setup0: psel/pen=%b%b addr=%h required 10 04", s_psel, s_penable, s_paddr);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                @(negedge PCLK);                 // cycle 3
                total++;
                if ({s_psel, s_penable} !== 2'b10 || s_paddr !== 8'h08) begin
                    bad++; $display("FAIL tie_setup1: psel/pen=%b%b addr=%h required 10 08", s_psel, s_penable, s_paddr);
                end
            end
            step();
            @(negedge PCLK);                     // cycle 2 / cycle 4
            total++;
            if (sb.size() == 0) begin
                bad++; $display("FAIL tie_sb%0d: scoreboard empty, required 1 entry", k);
            end else begin
                e = sb.pop_front();
                if (s_penable !== 1'b1 || s_paddr !== e.addr || s_pwdata !== e.data ||
                    m_pready[e.m] !== 1'b1 || m_pready[1 - e.m] !== 1'b0) begin
                    bad++; $display("FAIL tie_sb%0d: pen=%b addr=%h data=%h rdy0=%b rdy1=%b required 1 %h %h served m%0d only",
                                    k, s_penable, s_paddr, s_pwdata, m0_pready, m1_pready, e.addr, e.data, e.m);
                end
            end
            step();
            m_psel[k] = 1'b0; m_pen[k] = 1'b0;
        end
        @(negedge PCLK);                         // cycle 5
        total++;
        if (s_psel !== 1'b0) begin
            bad++; $display("FAIL tie_idle: S_PSEL got %b required 0", s_psel);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        s_pready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{addr: 8'h10 + 8'(i), data: 32'h0000_0100 + i, wr: 1'b1, m: 0});
            sb.push_back('{addr: 8'h80 + 8'(i), data: 32'h0000_0200 + i, wr: 1'b1, m: 1});
        end
        fork
            for (int i = 0; i < 6; i++) begin
                logic ok;
                apb_xfer(0, 1'b1, 8'h10 + 8'(i), 32'h0000_0100 + i, ok);
                total++;
                if (!ok) begin bad++; $display("FAIL b2b_m0_xfer%0d: no PREADY, required PREADY", i); end
            end
            for (int i = 0; i < 6; i++) begin
                logic ok;
                apb_xfer(1, 1'b1, 8'h80 + 8'(i), 32'h0000_0200 + i, ok);
                total++;
                if (!ok) begin bad++; $display("FAIL b2b_m1_xfer%0d: no PREADY, required PREADY", i); end
            end
            begin
                int seen = 0;
                int busy = 0;
                exp_t e;
                for (int c = 0; c < 100 && seen < 12; c++) begin
                    @(negedge PCLK);
                    if (s_psel) busy++;
                    if (s_psel && s_penable && s_pready) begin
                        total++;
                        if (sb.size() == 0) begin
                            bad++; $display("FAIL b2b_sb%0d: scoreboard empty, required entry", seen);
                        end else begin
                            e = sb.pop_front();
                            if (s_paddr !== e.addr || s_pwdata !== e.data ||
                                m_pready[e.m] !== 1'b1 || m_pready[1 - e.m] !== 1'b0) begin
                                bad++; $display("FAIL b2b_sb%0d: addr=%h data=%h rdy0=%b rdy1=%b required %h %h served m%0d",
                                                seen, s_paddr, s_pwdata, m0_pready, m1_pready, e.addr, e.data, e.m);
                            end
                        end
                        seen++;
                    end
                end
                total++;
                if (seen != 12 || busy != 24) begin
                    bad++; $display("FAIL b2b_count: completions=%0d busy_cycles=%0d required 12 24", seen, busy);
                end
            end
        join
    endtask

    task automatic test_timeout();
        exp_t e;
        do_reset();
        s_pready = 1'b0;
        s_prdata = 32'hDEAD_BEEF;
        drive_req(0, 1'b0, 8'h20, 32'h0);
        sb.push_back('{addr: 8'h20, data: 32'h0, wr: 1'b0, m: 0});
        step(); m_pen[0] = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) begin
            @(negedge PCLK);                     // ACCESS cycles 1..3
            total++;
            if (s_penable !== 1'b1 || m0_pready !== 1'b0 || m0_pslverr !== 1'b0) begin
                bad++; $display("FAIL to_wait%0d: pen=%b pready=%b pslverr=%b required 1 0 0",
                                k, s_penable, m0_pready, m0_pslverr);
            end
            step();
        end
        @(negedge PCLK);                         // 4th ACCESS cycle
        total++;
        if (m0_pready !== 1'b1 || m0_pslverr !== 1'b1 || m0_prdata !== 32'h0) begin
            bad++; $display("FAIL to_fire: pready=%b pslverr=%b prdata=%h required 1 1 00000000",
                            m0_pready, m0_pslverr, m0_prdata);
        end
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL to_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            if (s_paddr !== e.addr || s_pwrite !== e.wr) begin
                bad++; $display("FAIL to_sb: got %h %b required %h %b", s_paddr, s_pwrite, e.addr, e.wr);
            end
        end
        step(); m_psel[0] = 1'b0; m_pen[0] = 1'b0;
        @(negedge PCLK);
        total++;
        if (s_psel !== 1'b0 || m0_pready !== 1'b0) begin
            bad++; $display("FAIL to_idle: psel=%b pready=%b required 0 0", s_psel, m0_pready);
        end
    endtask

    task automatic test_reset_mid_access();
        int pulses = 0;
        do_reset();
        s_pready = 1'b0;
        drive_req(1, 1'b0, 8'h30, 32'h0);
        step(); m_pen[1] = 1'b1;
        step();
        @(negedge PCLK);                         // M1 ACCESS
        total++;
        if ({s_psel, s_penable} !== 2'b11 || m1_pready !== 1'b0) begin
            bad++; $display("FAIL rst_pre: psel/pen=%b%b pready=%b required 11 0", s_psel, s_penable, m1_pready);
        end
        #1 PRESETn = 1'b0;
        #1;
        total++;
        if (all_out !== '0) begin
            bad++; $display("FAIL rst_async: got %h required 0", all_out);
        end
        m_psel[1] = 1'b0; m_pen[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            if (m0_pready || m1_pready) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL rst_no_pready: pready pulses=%0d required 0", pulses);
        end
        step();
        PRESETn = 1'b1;
        drive_req(0, 1'b1, 8'h40, 32'h4);
        drive_req(1, 1'b1, 8'h50, 32'h5);
        step();
        @(negedge PCLK);
        total++;
        if (s_psel !== 1'b1 || s_paddr !== 8'h40) begin
            bad++; $display("FAIL rst_tie: psel=%b addr=%h required 1 40", s_psel, s_paddr);
        end
        idle_inputs();
    endtask

    initial begin
        PRESETn = 1'b0;
        idle_inputs();
        test_reset();
        test_uncontested_write();
        test_read();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_leftover: %0d entries required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
